// File: rtl/sprite_blitter.sv
// sprite_blitter: draws one rectangular 4bpp sprite per command from a
// synchronous sprite ROM into the back buffer, two horizontally adjacent
// pixels per cycle (one per framebuffer write port).  Pixels are clipped to
// the screen and transparent pixels are skipped.  The block stalls while the
// framebuffer reports a clear in progress.
//
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready = idle)
//   cmd_x, cmd_y          signed sprite top-left corner (screen pixels)
//   cmd_w, cmd_h          width (bit 0 ignored) and height of the sprite
//   cmd_base              ROM word address of the first pixel pair
//   spr_addr / spr_data   ROM read port, one-cycle read latency
//   fb_resetting          back-buffer clear in progress: freeze everything
//   addr_wr1/2, data_wr1/2, wr1_en/wr2_en   framebuffer write ports
//   busy                  command in progress
module sprite_blitter #(
    parameter int         FB_WIDTH    = 320,
    parameter int         FB_HEIGHT   = 240,
    parameter int         SPR_ADDR_W  = 16,
    parameter logic [3:0] TRANSPARENT = 4'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [10:0]           cmd_x,
    input  logic [10:0]           cmd_y,
    input  logic [7:0]            cmd_w,
    input  logic [7:0]            cmd_h,
    input  logic [SPR_ADDR_W-1:0] cmd_base,
    output logic [SPR_ADDR_W-1:0] spr_addr,
    input  logic [7:0]            spr_data,
    input  logic                  fb_resetting,
    output logic [18:0]           addr_wr1,
    output logic [18:0]           addr_wr2,
    output logic [3:0]            data_wr1,
    output logic [3:0]            data_wr2,
    output logic                  wr1_en,
    output logic                  wr2_en,
    output logic                  busy
);
    localparam int STAGES = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_next;

    // [0] address stage (spr_addr presented), [1] ROM data stage
    logic [STAGES:0] vld_pipe;

    logic        stall, stall_q, accept, zero_cmd, row_end, last_pair;
    logic [10:0] x_q;
    logic [6:0]  w2_q, col_q;
    logic [7:0]  h_q, row_q;
    // Coordinates are 12-bit two's complement: wide enough for x + 2*126 + 1.
    logic [11:0] px0, py0, px1, py1;
    logic [18:0] fa0, row_fa, fa1, start_fa;
    logic [7:0]  data_hold, pix_data;
    logic        wr1_q, wr2_q;

    assign stall     = fb_resetting;
    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign zero_cmd  = (cmd_w < 8'd2) || (cmd_h == 8'd0);
    assign row_end   = (col_q == w2_q - 7'd1);
    assign last_pair = row_end && (row_q == h_q - 8'd1);

    // Screen address of the sprite origin, modulo 2^19.  Constant multiply,
    // done once per command; rows then advance by accumulation.
    assign start_fa = {{8{cmd_y[10]}}, cmd_y} * 19'(FB_WIDTH) + {{8{cmd_x[10]}}, cmd_x};

    // spr_addr is held during a stall, so the ROM output after the first
    // stalled cycle belongs to the address stage, not the data stage.  The
    // data-stage word is captured while fresh and replayed after a stall.
    assign pix_data = stall_q ? data_hold : spr_data;

    function automatic logic on_screen(input logic [11:0] px, input logic [11:0] py);
        return !px[11] && (px < 12'(FB_WIDTH)) && !py[11] && (py < 12'(FB_HEIGHT));
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = zero_cmd ? DRAIN : RUN;
            RUN:     if (!stall && last_pair) state_next = DRAIN;
            DRAIN:   if (!stall && !vld_pipe[1]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe  <= '0;
            stall_q   <= 1'b0;
            data_hold <= '0;
            x_q       <= '0;
            w2_q      <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            spr_addr  <= '0;
            px0       <= '0;
            py0       <= '0;
            fa0       <= '0;
            row_fa    <= '0;
            px1       <= '0;
            py1       <= '0;
            fa1       <= '0;
            addr_wr1  <= '0;
            addr_wr2  <= '0;
            data_wr1  <= '0;
            data_wr2  <= '0;
            wr1_q     <= 1'b0;
            wr2_q     <= 1'b0;
        end else begin
            stall_q <= stall;
            if (!stall_q) data_hold <= spr_data;

            // Acceptance is not blocked by a stall; the command simply
            // starts frozen.
            if (accept) begin
                x_q         <= cmd_x;
                w2_q        <= cmd_w[7:1];
                h_q         <= cmd_h;
                col_q       <= '0;
                row_q       <= '0;
                spr_addr    <= cmd_base;
                px0         <= {cmd_x[10], cmd_x};
                py0         <= {cmd_y[10], cmd_y};
                fa0         <= start_fa;
                row_fa      <= start_fa;
                vld_pipe[0] <= !zero_cmd;
            end else if (!stall && state == RUN) begin
                vld_pipe[0] <= !last_pair;
                if (!last_pair) begin
                    spr_addr <= spr_addr + 1'b1;
                    if (row_end) begin
                        col_q  <= '0;
                        row_q  <= row_q + 8'd1;
                        px0    <= {x_q[10], x_q};
                        py0    <= py0 + 12'd1;
                        row_fa <= row_fa + 19'(FB_WIDTH);
                        fa0    <= row_fa + 19'(FB_WIDTH);
                    end else begin
                        col_q <= col_q + 7'd1;
                        px0   <= px0 + 12'd2;
                        fa0   <= fa0 + 19'd2;
                    end
                end
            end

            if (!stall) begin
                vld_pipe[1] <= vld_pipe[0];
                px1         <= px0;
                py1         <= py0;
                fa1         <= fa0;
                addr_wr1    <= fa1;
                addr_wr2    <= fa1 + 19'd1;
                data_wr1    <= pix_data[3:0];
                data_wr2    <= pix_data[7:4];
                wr1_q <= vld_pipe[1] && on_screen(px1, py1) && (pix_data[3:0] != TRANSPARENT);
                wr2_q <= vld_pipe[1] && on_screen(px1 + 12'd1, py1) && (pix_data[7:4] != TRANSPARENT);
            end
        end
    end

    // The held write reappears once the stall drops.
    assign wr1_en = wr1_q && !stall;
    assign wr2_en = wr2_q && !stall;

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;
    localparam int FBW = 320;
    localparam int FBH = 240;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_x = '0;
    logic [10:0] cmd_y = '0;
    logic [7:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [15:0] cmd_base = '0;
    logic [15:0] spr_addr;
    logic [7:0]  spr_data = '0;
    logic        fb_resetting = 1'b0;
    logic [18:0] addr_wr1, addr_wr2;
    logic [3:0]  data_wr1, data_wr2;
    logic        wr1_en, wr2_en, busy;

    logic [7:0]  rom [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    sprite_blitter dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_base(cmd_base),
        .spr_addr(spr_addr), .spr_data(spr_data), .fb_resetting(fb_resetting),
        .addr_wr1(addr_wr1), .addr_wr2(addr_wr2), .data_wr1(data_wr1), .data_wr2(data_wr2),
        .wr1_en(wr1_en), .wr2_en(wr2_en), .busy(busy)
    );

    always #5 clock = ~clock;

    // Sprite ROM with one cycle of read latency.
    always @(posedge clock) spr_data <= rom[spr_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Address/data only matter where the strobe is high.
    function automatic logic [63:0] pack(input logic rdy, input logic bsy, input logic e1,
                                         input logic e2, input logic [18:0] a1, input logic [18:0] a2,
                                         input logic [3:0] d1, input logic [3:0] d2);
        return {14'd0, rdy, bsy, e1, e2, e1 ? a1 : 19'd0, e1 ? d1 : 4'd0,
                e2 ? a2 : 19'd0, e2 ? d2 : 4'd0};
    endfunction

    function automatic logic [63:0] observed();
        return pack(cmd_ready, busy, wr1_en, wr2_en, addr_wr1, addr_wr2, data_wr1, data_wr2);
    endfunction

    // mode < 0: random words with frequent transparent nibbles
    task automatic fill_rom(input int base, input int n, input int mode);
        logic [31:0] v;
        for (int k = 0; k < n; k++) begin
            v = $urandom;
            if (v[8]) v[3:0] = 4'h0;
            if (v[9]) v[7:4] = 4'h0;
            rom[(base + k) & 32'hFFFF] = (mode < 0) ? v[7:0] : 8'(mode);
        end
    endtask

    // Called at negedge+1 of a cycle where cmd_ready is expected high.
    // Stall drives fb_resetting for cycles T+s0 .. T+s0+slen-1 (T = accept).
    // Model: e counts unstalled cycles after T; pair k is written when e==k+2,
    // ready returns when e reaches N+2 (or 1 for an empty command).
    task automatic run_cmd(input string tag, input int x, input int y, input int w,
                           input int h, input int base, input int s0, input int slen);
        int w2, n, thr, e, k, px, py;
        logic [7:0]  word;
        logic        st, x1, x2, rdy;
        logic [18:0] a1, a2;
        logic [63:0] exp_v;
        w2  = (w & 254) / 2;
        n   = w2 * h;
        thr = (n == 0) ? 1 : n + 2;
        cmd_x        = x[10:0];
        cmd_y        = y[10:0];
        cmd_w        = w[7:0];
        cmd_h        = h[7:0];
        cmd_base     = base[15:0];
        cmd_valid    = 1'b1;
        fb_resetting = (s0 == 0) && (slen > 0);
        #1;
        check({tag, ":accept_ready"}, 64'(cmd_ready), 64'd1);
        @(posedge clock);
        e = 0;
        for (int t = 1; t < thr + slen + 8; t++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            cmd_x     = 11'($urandom);
            cmd_y     = 11'($urandom);
            cmd_w     = 8'($urandom);
            cmd_h     = 8'($urandom);
            cmd_base  = 16'($urandom);
            st = (t >= s0) && (t < s0 + slen);
            fb_resetting = st;
            #1;
            rdy = (e >= thr);
            x1 = 1'b0; x2 = 1'b0; a1 = '0; a2 = '0; word = '0;
            if (!st && e >= 2 && e <= n + 1) begin
                k    = e - 2;
                px   = x + 2 * (k % w2);
                py   = y + k / w2;
                word = rom[(base + k) & 32'hFFFF];
                x1 = (px >= 0) && (px < FBW) && (py >= 0) && (py < FBH) && (word[3:0] != 4'h0);
                x2 = (px + 1 >= 0) && (px + 1 < FBW) && (py >= 0) && (py < FBH) && (word[7:4] != 4'h0);
                a1 = 19'(py * FBW + px);
                a2 = 19'(py * FBW + px + 1);
            end
            exp_v = pack(rdy, !rdy, x1, x2, a1, a2, word[3:0], word[7:4]);
            check($sformatf("%s:t%0d", tag, t), observed(), exp_v);
            if (t == 1) check({tag, ":spr_addr_base"}, 64'(spr_addr), 64'(base & 32'hFFFF));
            if (rdy) break;
            if (!st) e++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;

        // Reset state
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            check("rst_ctl", 64'({cmd_ready, busy, wr1_en, wr2_en, spr_addr}), 64'd0);
            check("rst_out", 64'({addr_wr1, addr_wr2, data_wr1, data_wr2}), 64'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        check("rst_release_ready", 64'(cmd_ready), 64'd1);

        // Directed cases
        fill_rom(256, 4, 'h21);
        run_cmd("basic", 10, 5, 4, 2, 256, -1, 0);
        fill_rom(256, 4, 'h30);
        run_cmd("transp_right_only", 10, 5, 4, 2, 256, -1, 0);
        fill_rom(256, 4, 'h00);
        run_cmd("transp_all", 10, 5, 4, 2, 256, -1, 0);
        fill_rom(512, 4, 'h21);
        run_cmd("clip_neg", -1, -1, 4, 2, 512, -1, 0);
        run_cmd("clip_right", 318, 0, 4, 1, 512, -1, 0);
        run_cmd("clip_bottom", 100, 238, 4, 3, 512, -1, 0);
        fill_rom(1024, 6, -1);
        run_cmd("stall", 40, 20, 6, 2, 1024, 4, 7);
        run_cmd("stall_at_accept", 40, 20, 12, 1, 1024, 0, 3);
        run_cmd("w0", 5, 5, 0, 3, 1024, -1, 0);
        run_cmd("h0", 5, 5, 4, 0, 1024, -1, 0);
        run_cmd("w1", 5, 5, 1, 2, 1024, -1, 0);
        fill_rom(2048, 4, -1);
        run_cmd("odd_w5", 7, 9, 5, 2, 2048, -1, 0);
        fill_rom(16'hFFFE, 4, -1);
        run_cmd("rom_wrap", 200, 100, 4, 2, 16'hFFFE, -1, 0);

        // Reset in the middle of a command
        fill_rom(4096, 16, 'h55);
        cmd_x = 11'd50; cmd_y = 11'd50; cmd_w = 8'd16; cmd_h = 8'd2; cmd_base = 16'd4096;
        cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            check("midrst_in_reset", 64'({cmd_ready, busy, wr1_en, wr2_en}), 64'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("midrst_after", 64'({cmd_ready, busy, wr1_en, wr2_en}), 64'b1000);
        end
        fill_rom(300, 6, -1);
        run_cmd("after_reset", 30, 30, 6, 2, 300, -1, 0);

        // Randomized commands, back to back, with occasional stalls
        for (int i = 0; i < 25; i++) begin
            int x, y, w, h, base, s0, slen;
            x    = $urandom_range(0, 380) - 40;
            y    = $urandom_range(0, 270) - 20;
            w    = $urandom_range(0, 20);
            h    = $urandom_range(0, 6);
            base = $urandom_range(0, 65535);
            s0   = $urandom_range(0, 14);
            slen = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
            fill_rom(base, (w / 2) * h, -1);
            run_cmd($sformatf("rand%0d", i), x, y, w, h, base, s0, slen);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
